// File: rtl/ram_2x412_queue_ctrl_pkg.sv
// Shared widths and types for the 2-entry x 412-bit RAM-backed queue.
package ram_queue_pkg;
  localparam int QUEUE_DATA_W = 412;
  localparam int QUEUE_DEPTH  = 2;
  localparam int QUEUE_PTR_W  = $clog2(QUEUE_DEPTH);

  typedef logic [QUEUE_PTR_W-1:0] queue_ptr_t;
  typedef logic [QUEUE_PTR_W:0]   queue_cnt_t;
endpackage

// File: rtl/ram_2x412_queue_ctrl_if.sv
// Producer/consumer ready-valid bundle for the queue controller.
// A beat transfers on an edge where valid & ready are both 1; valid never waits on ready.
interface ram_2x412_queue_ctrl_if #(
  parameter int DATA_W = 412
);
  logic              enq_valid;
  logic              enq_ready;
  logic [DATA_W-1:0] enq_bits;
  logic              deq_valid;
  logic              deq_ready;
  logic [DATA_W-1:0] deq_bits;

  modport slave (
    input  enq_valid, enq_bits, deq_ready,
    output enq_ready, deq_valid, deq_bits
  );

  modport master (
    output enq_valid, enq_bits, deq_ready,
    input  enq_ready, deq_valid, deq_bits
  );
endinterface

// File: rtl/ram_2x412_queue_ctrl_ptr.sv
// Wrapping pointer register with increment enable and synchronous clear.
module ram_queue_ptr #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear)    ptr_d = '0;
    else if (inc) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/ram_2x412_queue_ctrl.sv
// 2-deep ready/valid queue controller driving an external async-read/sync-write RAM.
// Define RAM_QUEUE_PIPE_EN to let a full queue accept an enqueue while it dequeues.
module ram_2x412_queue_ctrl
  import ram_queue_pkg::*;
#(
  parameter int DATA_W = QUEUE_DATA_W,
  parameter int DEPTH  = QUEUE_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  ram_2x412_queue_ctrl_if.slave     q_if,
  output logic [$clog2(DEPTH):0]    count,
  output logic [$clog2(DEPTH)-1:0]  ram_W0_addr,
  output logic                      ram_W0_en,
  output logic [DATA_W-1:0]         ram_W0_data,
  output logic [$clog2(DEPTH)-1:0]  ram_R0_addr,
  output logic                      ram_R0_en,
  input  logic [DATA_W-1:0]         ram_R0_data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head, tail;
  logic             maybe_full_q, maybe_full_d;
  logic             ptr_match, empty, full;
  logic             enq_fire, deq_fire;
  logic             enq_ready, deq_valid;
  logic [PTR_W-1:0] occ;

  assign ptr_match = (head == tail);
  assign empty     = ptr_match & ~maybe_full_q;
  assign full      = ptr_match &  maybe_full_q;

`ifdef RAM_QUEUE_PIPE_EN
  // Async read lets the freed head slot be overwritten on the same edge it is read.
  assign enq_ready = (~full | q_if.deq_ready) & reset;
`else
  assign enq_ready = ~full & reset;
`endif
  assign deq_valid = ~empty & reset;

  assign enq_fire = q_if.enq_valid & enq_ready;
  assign deq_fire = deq_valid & q_if.deq_ready;

  assign q_if.enq_ready = enq_ready;
  assign q_if.deq_valid = deq_valid;
  assign q_if.deq_bits  = ram_R0_data;

  assign ram_W0_addr = tail;
  assign ram_W0_en   = enq_fire & ~flush;
  assign ram_W0_data = q_if.enq_bits;
  assign ram_R0_addr = head;
  assign ram_R0_en   = deq_valid;

  ram_queue_ptr #(.W(PTR_W)) u_head (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .inc   (deq_fire),
    .ptr   (head)
  );

  ram_queue_ptr #(.W(PTR_W)) u_tail (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .inc   (enq_fire),
    .ptr   (tail)
  );

  always_comb begin
    maybe_full_d = maybe_full_q;
    if (flush)                      maybe_full_d = 1'b0;
    else if (enq_fire != deq_fire)  maybe_full_d = enq_fire;
  end

  always_ff @(posedge clock) begin
    if (!reset) maybe_full_q <= 1'b0;
    else        maybe_full_q <= maybe_full_d;
  end

  assign occ   = tail - head;
  assign count = full ? (PTR_W+1)'(DEPTH) : {1'b0, occ};
endmodule

// File: doc/ram_2x412_queue_ctrl.md
Name: ram_2x412_queue_ctrl

Overview:
- Ready/valid FIFO controller that sequences one 2-entry x 412-bit storage RAM, which has one async-read port and one sync-write port, as a 2-deep queue.
- Sits between a 412-bit producer and a 412-bit consumer in the core pipeline.
- Owns the read/write pointers, the full/empty tracking and flush.
- Drives every RAM port. The RAM is instantiated outside this block.

Parameters:
- DATA_W, 412, payload width; must equal the RAM word width.
- DEPTH, 2, number of entries; must be a power of 2, minimum 2.
- PTR_W, $clog2(DEPTH) (1), pointer and RAM address width; derived, not overridable.

Ports:
- clock  in  1  single clock for all state; also drives RAM W0_clk and R0_clk.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- flush  in  1  synchronous clear of all queue contents.
- enq_valid  in  1  producer has data.
- enq_ready  out  1  queue can accept data.
- enq_bits  in  DATA_W  producer payload.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  consumer takes the head entry.
- deq_bits  out  DATA_W  head payload, equal to ram_R0_data.
- count  out  PTR_W+1  number of occupied entries, 0..DEPTH.
- ram_W0_addr  out  PTR_W  write address, equal to the tail pointer.
- ram_W0_en  out  1  write enable.
- ram_W0_data  out  DATA_W  equal to enq_bits.
- ram_R0_addr  out  PTR_W  read address, equal to the head pointer.
- ram_R0_en  out  1  equal to deq_valid.
- ram_R0_data  in  DATA_W  async read data from the RAM.

Behaviour:
- State:
  - head and tail pointers, PTR_W bits each, wrapping modulo DEPTH.
  - maybe_full, 1 bit.
- Derived signals:
  - ptr_match = (head == tail)
  - empty = ptr_match & !maybe_full
  - full = ptr_match & maybe_full
- Handshake fires:
  - enq_fire = enq_valid & enq_ready
  - deq_fire = deq_valid & deq_ready
- Combinational outputs:
  - enq_ready = !full & reset
  - deq_valid = !empty & reset
  - ram_W0_en = enq_fire & !flush
  - deq_bits shows the head entry in the same cycle it becomes valid, with zero-cycle read latency.
- Enqueue/dequeue timing:
  - An entry written on edge N is visible on deq_bits after edge N. Enqueue-to-dequeue latency is 1 cycle; there is no bypass.
  - On enq_fire: tail <= tail+1.
  - On deq_fire: head <= head+1.
  - If enq_fire != deq_fire: maybe_full <= enq_fire.
- Flush:
  - When flush=1, on the next edge head, tail and maybe_full all become 0.
  - Flush overrides enq/deq in the same cycle; the RAM write is suppressed.
  - Handshake outputs stay combinationally valid during the flush cycle. A deq_fire in that cycle is honoured by the consumer, and the entry is discarded regardless.
- Count:
  - count = full ? DEPTH : (tail - head) mod DEPTH.
  - Width PTR_W+1, zero-extended.
- Reset (reset=0 sampled at an edge):
  - head, tail and maybe_full become 0.
  - While reset=0: enq_ready=0, deq_valid=0, ram_W0_en=0, ram_R0_en=0.
  - count reflects the current state.
  - Reset mid-operation discards all entries.
  - After reset deasserts: enq_ready=1, deq_valid=0, count=0.
- Boundaries:
  - Full with deq_fire and enq_valid: enq_ready=0 (unless the optional feature is on). Next cycle count=DEPTH-1.
  - Empty with enq_fire and deq_ready: deq_valid=0 this cycle, so only the enqueue occurs.
  - Simultaneous enq_fire and deq_fire when partly full: pointers both advance, maybe_full and count unchanged.
  - Pointer wrap from DEPTH-1 to 0 is natural modulo arithmetic.
- RAM contents are never reset. Stale data is unobservable because ram_R0_en=0 when empty.

Optional Feature:
- Macro: RAM_QUEUE_PIPE_EN.
- Defined: enq_ready = (!full | deq_ready) & reset.
  - When full and deq_fire, an enqueue is accepted in the same cycle into the slot being freed.
  - This is legal because the read is async, so the RAM samples the old value before the edge.
  - Throughput at full is 1 per cycle.
- Not defined: enq_ready = !full & reset. A full queue needs one bubble cycle before it accepts again.

Decomposition:
- Shared package ram_queue_pkg holds:
  - the localparam QUEUE_DATA_W = 412 and QUEUE_DEPTH = 2;
  - the typedef queue_ptr_t, logic [PTR_W-1:0];
  - the typedef queue_cnt_t, logic [PTR_W:0].
- One sub-module is natural: ram_queue_ptr, a wrapping pointer register with increment enable and sync clear. It is instantiated twice, for head and tail.
- Full/empty logic and maybe_full stay in the top.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> enq_ready=1, deq_valid=0, count=0, ram_W0_en=0 throughout reset.
- Fill:
  - enq 412'hA5..A5 then 412'h5A..5A with deq_ready=0 -> after edge 1: count=1, deq_valid=1, deq_bits=A5..A5; after edge 2: count=2, enq_ready=0.
  - Further enq_valid is ignored, with no RAM write.
- Drain with wrap: from the full state above, deq_ready=1 for 2 cycles -> deq_bits A5..A5 then 5A..5A, count 2->1->0. Head wraps to 0 and deq_valid=0.
- Streaming at count=1: enq_valid=deq_ready=1 for 10 cycles with an incrementing payload 1..10 -> count stays 1. Payloads come out in order, one cycle behind.
- Flush priority: at count=1, assert flush with enq_fire -> next cycle count=0, deq_valid=0, ram_W0_en=0 in the flush cycle. Also assert reset=0 mid-stream -> same cleared state.
- Full plus deq plus enq:
  - With RAM_QUEUE_PIPE_EN: enq_ready=1, the entry is written to the freed slot, count stays 2.
  - Without it: enq_ready=0 and count becomes 1.
